// File: rtl/line_decoder.sv
// line_decoder: 3-to-8 one-hot line decoder with active-high enable.
// Select index is {A,B,C} with A as MSB. The mapping is MSB-first:
// sel 0 drives F[7] and sel 7 drives F[0]. By default F is registered
// behind a synchronous active-low reset. With OUT_REG = 0 the decode is
// combinational, and clk/rst_n are left unconnected inside.
module line_decoder #(
    parameter bit OUT_REG = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       Enable,
    input  logic       A,
    input  logic       B,
    input  logic       C,
    output logic [7:0] F
);

    logic [2:0] sel;
    logic [7:0] dec;

    assign sel = {A, B, C};

    // One-hot decode, MSB-first; disabled decoder drives all lines low
    always_comb begin
        dec = 8'h00;
        if (Enable) begin
            dec = 8'b1000_0000 >> sel;
        end
    end

    generate
        if (OUT_REG) begin : g_reg
            logic [7:0] f_d;
            logic [7:0] f_q;

            // Next-state: reset wins over enable and selects
            always_comb begin
                f_d = dec;
                if (!rst_n) begin
                    f_d = 8'h00;
                end
            end

            // Output register; reset is sampled only on the rising edge
            always_ff @(posedge clk) begin
                f_q <= f_d;
            end

            assign F = f_q;
        end else begin : g_comb
            assign F = dec;
        end
    endgenerate

endmodule

// File: tb/tb_line_decoder.sv
// tb_line_decoder: directed checks of the registered decoder (default
// build) and of a combinational build (OUT_REG = 0) with its clock held low.
module tb_line_decoder;

    // ---------------- clock / reset ----------------
    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       a, b, c;
    logic [7:0] f;

    logic       c_clk;
    logic       c_rst_n;
    logic       c_enable;
    logic       c_a, c_b, c_c;
    logic [7:0] c_f;

    int checks_total;
    int checks_passed;

    logic [7:0] exp_tab [0:7];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    line_decoder #(.OUT_REG(1'b1)) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .Enable (enable),
        .A      (a),
        .B      (b),
        .C      (c),
        .F      (f)
    );

    line_decoder #(.OUT_REG(1'b0)) u_dut_comb (
        .clk    (c_clk),
        .rst_n  (c_rst_n),
        .Enable (c_enable),
        .A      (c_a),
        .B      (c_b),
        .C      (c_c),
        .F      (c_f)
    );

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks_total++;
        if (got === exp) begin
            checks_passed++;
        end else begin
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic en, input logic [2:0] s);
        enable = en;
        {a, b, c} = s;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        checks_total  = 0;
        checks_passed = 0;
        exp_tab[0] = 8'b1000_0000;
        exp_tab[1] = 8'b0100_0000;
        exp_tab[2] = 8'b0010_0000;
        exp_tab[3] = 8'b0001_0000;
        exp_tab[4] = 8'b0000_1000;
        exp_tab[5] = 8'b0000_0100;
        exp_tab[6] = 8'b0000_0010;
        exp_tab[7] = 8'b0000_0001;

        c_clk    = 1'b0;
        c_rst_n  = 1'b1;
        c_enable = 1'b0;
        {c_a, c_b, c_c} = 3'b000;

        // 1. reset held two edges with an active select
        rst_n = 1'b0;
        drive(1'b1, 3'b101);
        tick();
        check("reset_edge1", f, 8'h00);
        tick();
        check("reset_edge2", f, 8'h00);
        rst_n = 1'b1;
        tick();
        check("reset_release", f, 8'b0000_0100);

        // 2. basic decode
        drive(1'b1, 3'b011);
        #2;
        check("hold_between_edges", f, 8'b0000_0100);
        tick();
        check("basic_sel3", f, 8'b0001_0000);

        // 3. exhaustive walk
        for (int s = 0; s < 8; s++) begin
            drive(1'b1, 3'(s));
            tick();
            check($sformatf("walk_sel%0d", s), f, exp_tab[s]);
            check($sformatf("walk_onehot%0d", s), 8'($countones(f)), 8'd1);
        end

        // 4. disable across all selects, then re-enable
        for (int s = 0; s < 8; s++) begin
            drive(1'b0, 3'(s));
            tick();
            check($sformatf("disable_sel%0d", s), f, 8'h00);
        end
        drive(1'b1, 3'b111);
        tick();
        check("reenable_sel7", f, 8'b0000_0001);

        // 5. mid-operation reset pulse
        drive(1'b1, 3'b001);
        tick();
        check("pre_reset_sel1", f, 8'b0100_0000);
        rst_n = 1'b0;
        #2;
        check("reset_not_async", f, 8'b0100_0000);
        tick();
        check("mid_reset", f, 8'h00);
        rst_n = 1'b1;
        tick();
        check("post_reset_sel1", f, 8'b0100_0000);

        // 6. combinational build, clock stopped
        c_enable = 1'b1;
        {c_a, c_b, c_c} = 3'b011;
        #5;
        check("comb_sel3", c_f, 8'b0001_0000);
        c_rst_n = 1'b0;
        #5;
        check("comb_rst_ignored", c_f, 8'b0001_0000);
        {c_a, c_b, c_c} = 3'b000;
        #5;
        check("comb_sel0", c_f, 8'b1000_0000);
        {c_a, c_b, c_c} = 3'b110;
        #5;
        check("comb_sel6", c_f, 8'b0000_0010);
        c_enable = 1'b0;
        #5;
        check("comb_disable", c_f, 8'h00);

        // ---------------- report ----------------
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
